mem_access_seq: RTL

- Upstream sequencer for the 16x8 data RAM stage.
- Owns the free-running machine phase counter `cnt_clk`.
- Accepts single load/store requests from the core. Holds `WR`/`Addr`/`Write_data` stable through the RAM access phase (`cnt_clk==CNT_CLK+1`).
- For reads, captures the RAM `Dout` on the following phase and returns it with a one-cycle response pulse.

---
 rtl/mem_access_seq.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/mem_access_seq.sv
// ---------------------------------------------------------------------------
// mem_access_seq
//
// Upstream sequencer for the 16x8 data RAM stage. It owns the free-running
// machine phase counter and turns single load/store requests from the core
// into a RAM access that is held stable through the RAM's access phase
// (cnt_clk == CNT_CLK+1). Loads capture the RAM output on the following
// phase and report it with a one-cycle response pulse.
//
// Ports:
//   clk         - single clock, rising edge
//   rst         - synchronous active-high reset
//   req         - access request, taken only while req_ready is high
//   req_we      - 1 = store, 0 = load
//   req_addr    - RAM address of the request
//   req_wdata   - store data
//   req_ready   - high while idle (combinational)
//   cnt_clk     - machine phase counter (registered)
//   WR          - RAM write strobe (registered)
//   Addr        - RAM address (registered)
//   Write_data  - RAM write data (registered)
//   mem_dout    - RAM data output
//   rsp_valid   - one-cycle completion pulse (registered)
//   rsp_rdata   - last load result, held until the next load completes
//   stall_cnt   - cycles spent waiting for the access phase (optional)
//   busy        - high while a transaction is in flight
//
// Optional feature macro: MEM_ACCESS_SEQ_STALL_CNT_EN
//   When defined, adds the saturating 8-bit stall_cnt output.
// ---------------------------------------------------------------------------
module mem_access_seq #(
  parameter int SIZE_CNT  = 3,
  parameter int CNT_CLK   = 2,
  parameter int NUM_PHASE = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req,
  input  logic                req_we,
  input  logic [3:0]          req_addr,
  input  logic [7:0]          req_wdata,
  output logic                req_ready,
  output logic [SIZE_CNT:0]   cnt_clk,
  output logic                WR,
  output logic [3:0]          Addr,
  output logic [7:0]          Write_data,
  input  logic [7:0]          mem_dout,
  output logic                rsp_valid,
  output logic [7:0]          rsp_rdata,
`ifdef MEM_ACCESS_SEQ_STALL_CNT_EN
  output logic [7:0]          stall_cnt,
`endif
  output logic                busy
);

  localparam int CW = SIZE_CNT + 1;
  localparam logic [CW-1:0] ACCESS_PHASE = CW'(CNT_CLK + 1);
  localparam logic [CW-1:0] LAST_PHASE   = CW'(NUM_PHASE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    READ  = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            wr_q, wr_d;
  logic            we_q, we_d;
  logic [3:0]      addr_q, addr_d;
  logic [7:0]      wdata_q, wdata_d;
  logic            valid_q, valid_d;
  logic [7:0]      rdata_q, rdata_d;
  logic            access_phase;

  assign access_phase = (cnt_q == ACCESS_PHASE);

  // The phase counter free-runs regardless of the FSM so that the RAM stage
  // and this sequencer always agree on which cycle is the access phase.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (cnt_q == LAST_PHASE) begin
      cnt_d = '0;
    end
  end

  // Next-state and registered-output logic. WR is dropped at the same edge
  // the RAM samples it, so it can never be high outside ARMED. A request
  // arriving during the access phase itself enters ARMED after that phase
  // has passed and therefore waits for the next one.
  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (req) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          wr_d    = req_we;
          we_d    = req_we;
          state_d = ARMED;
        end else begin
          wr_d = 1'b0;
        end
      end
      ARMED: begin
        if (access_phase) begin
          wr_d    = 1'b0;
          state_d = we_q ? DONE : READ;
        end
      end
      READ: begin
        rdata_d = mem_dout;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        wr_d    = 1'b0;
        state_d = IDLE;
      end
    endcase

    valid_d = (state_d == DONE);
  end

  // State and output registers; reset takes priority over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      valid_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      valid_q <= valid_d;
      rdata_q <= rdata_d;
    end
  end

`ifdef MEM_ACCESS_SEQ_STALL_CNT_EN
  logic [7:0] stall_q, stall_d;

  // Counts cycles spent armed but not yet at the access phase, saturating
  // so a long-running system never wraps back to a misleading small value.
  always_comb begin
    stall_d = stall_q;
    if (state_q == ARMED && !access_phase && stall_q != 8'hFF) begin
      stall_d = stall_q + 8'd1;
    end
  end

  // Stall counter register, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt = stall_q;
`endif

  assign req_ready  = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign cnt_clk    = cnt_q;
  assign WR         = wr_q;
  assign Addr       = addr_q;
  assign Write_data = wdata_q;
  assign rsp_valid  = valid_q;
  assign rsp_rdata  = rdata_q;

endmodule
